// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a big-endian byte stream into 16-bit words,
// writes them to consecutive addresses and keeps the CPU in reset until the program is in place.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [15:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StWrite,
        StDone,
        StErr
    } state_t;

    state_t          state_q;
    logic [15:0]     len_q;
    logic [7:0]      hi_q;
    logic [15:0]     word_q;
    logic [ADDR_W:0] count_q;

    logic            accept;
    logic [15:0]     len_full;
    logic [ADDR_W:0] count_inc;

    assign accept    = rx_valid & rx_ready;
    assign len_full  = {len_q[15:8], rx_data};
    assign count_inc = count_q + (ADDR_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLenHi;
            len_q   <= '0;
            hi_q    <= '0;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                StLenHi: begin
                    if (accept) begin
                        len_q[15:8] <= rx_data;
                        state_q     <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (accept) begin
                        len_q[7:0] <= rx_data;
                        if (len_full == 16'd0) begin
                            state_q <= StDone;
                        end else if (32'(len_full) > DEPTH) begin
                            state_q <= StErr;
                        end else begin
                            state_q <= StDataHi;
                        end
                    end
                end
                StDataHi: begin
                    if (accept) begin
                        hi_q    <= rx_data;
                        state_q <= StDataLo;
                    end
                end
                StDataLo: begin
                    // word_q only changes once both bytes are in, so wdata never shows a half word
                    if (accept) begin
                        word_q  <= {hi_q, rx_data};
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    count_q <= count_inc;
                    if (32'(count_inc) == 32'(len_q)) begin
                        state_q <= StDone;
                    end else begin
                        state_q <= StDataHi;
                    end
                end
                StDone, StErr: ;
                default: state_q <= StLenHi;
            endcase
        end
    end

    assign rx_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                      (state_q == StDataHi) || (state_q == StDataLo);
    // Reset wins over a pending write so the memory never captures on a reset edge.
    assign we           = (state_q == StWrite) && !reset;
    assign waddr        = count_q[ADDR_W-1:0];
    assign wdata        = word_q;
    assign cpu_hold     = (state_q != StDone);
    assign done         = (state_q == StDone);
    assign error        = (state_q == StErr);
    assign words_loaded = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams push expected writes, a negedge
// monitor pops and compares each memory write and checks release timing.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] mem[256];
    int          errors    = 0;
    int          checks    = 0;
    int          ncyc      = 0;
    int          last_acc  = 0;
    int          len_acc   = 0;
    int          exp_lat   = -1;
    logic        done_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_we: waddr=%0h wdata=%0h, required no write", waddr, wdata);
            end else begin
                e = sb.pop_front();
                chk("waddr", 32'(waddr), 32'(e.a));
                chk("wdata", 32'(wdata), 32'(e.d));
            end
            chk("ready_in_write", 32'(rx_ready), 32'd0);
            mem[waddr] = wdata;
        end
        chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
        if (done && !done_prev) begin
            chk("sb_empty_at_done", 32'(sb.size()), 32'd0);
            if (exp_lat >= 0) chk("done_latency", 32'(ncyc - len_acc), 32'(exp_lat));
        end
        done_prev = done;
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (rx_ready) begin
                last_acc = ncyc;
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte %0h not accepted, required accept", b);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=0, required 1");
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (2) @(negedge clk);

        // Reset state.
        do_reset();
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);

        // Two words, valid held high: done 3N cycles after LEN_LO accept.
        exp_lat = 7;
        push(8'd0, 16'h1234);
        push(8'd1, 16'hABCD);
        send_byte(8'h00);
        send_byte(8'h02);
        len_acc = last_acc;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        idle();
        wait_done();
        chk("t1_words", 32'(words_loaded), 32'd2);
        chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);

        // Empty program.
        do_reset();
        exp_lat = 1;
        send_byte(8'h00);
        send_byte(8'h00);
        len_acc = last_acc;
        idle();
        wait_done();
        chk("t2_words", 32'(words_loaded), 32'd0);

        // Oversized header.
        do_reset();
        exp_lat = -1;
        send_byte(8'h01);
        send_byte(8'h01);
        idle();
        @(negedge clk);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_rx_ready", 32'(rx_ready), 32'd0);
        chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_extra_ready", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;
        chk("t3_words", 32'(words_loaded), 32'd0);
        do_reset();
        chk("t3_error_cleared", 32'(error), 32'd0);

        // Three words with valid toggling between bytes.
        push(8'd0, 16'hDEAD);
        push(8'd1, 16'hBEEF);
        push(8'd2, 16'h0F0F);
        send_byte(8'h00); idle();
        send_byte(8'h03); idle();
        send_byte(8'hDE); idle();
        send_byte(8'hAD); idle();
        send_byte(8'hBE); idle();
        send_byte(8'hEF); idle();
        send_byte(8'h0F); idle();
        send_byte(8'h0F); idle();
        wait_done();
        chk("t4_mem0", 32'(mem[0]), 32'h0000DEAD);
        chk("t4_mem1", 32'(mem[1]), 32'h0000BEEF);
        chk("t4_mem2", 32'(mem[2]), 32'h00000F0F);
        chk("t4_words", 32'(words_loaded), 32'd3);
        chk("t4_wdata_hold", 32'(wdata), 32'h00000F0F);

        // Reset in DATA_LO, then reload.
        do_reset();
        push(8'd0, 16'h0101);
        push(8'd1, 16'h0202);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h02);
        send_byte(8'h03);
        idle();
        do_reset();
        chk("t5_words", 32'(words_loaded), 32'd0);
        chk("t5_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t5_rx_ready", 32'(rx_ready), 32'd1);
        chk("t5_we", 32'(we), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        exp_lat = 4;
        push(8'd0, 16'h7FFF);
        send_byte(8'h00);
        send_byte(8'h01);
        len_acc = last_acc;
        send_byte(8'h7F);
        send_byte(8'hFF);
        idle();
        wait_done();
        chk("t5_mem0", 32'(mem[0]), 32'h00007FFF);
        chk("t5_reload_words", 32'(words_loaded), 32'd1);

        // Full-depth program.
        do_reset();
        exp_lat = 3 * 256 + 1;
        for (int i = 0; i < 256; i++) push(8'(i), 16'(i));
        send_byte(8'h01);
        send_byte(8'h00);
        len_acc = last_acc;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00);
            send_byte(8'(i));
        end
        idle();
        wait_done();
        chk("t6_words", 32'(words_loaded), 32'd256);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_mem255", 32'(mem[255]), 32'h000000FF);
        chk("t6_mem128", 32'(mem[128]), 32'h00000080);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the writer side of the instruction memory that the CPU fetch path reads.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit instructions and writes them to consecutive instruction-memory addresses through the memory's write port.
- Holds the CPU in reset until the whole program is written.
- Sits between the host byte source (UART RX or testbench) and instr_mem/cpu_top.

Parameters:
- ADDR_W, 8, instruction-memory address width in words.
- DEPTH, 256, number of writable words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- we  output  1  instruction-memory write enable.
- waddr  output  ADDR_W  instruction-memory write address.
- wdata  output  16  instruction word to write.
- cpu_hold  output  1  drives cpu_top reset; 1 = CPU held.
- done  output  1  program fully loaded.
- error  output  1  length header exceeded DEPTH.
- words_loaded  output  ADDR_W+1  count of words written so far.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Byte transfer: a byte is accepted on a rising clk edge where rx_valid=1 and rx_ready=1. No other condition accepts a byte.
- Stream format, all values big-endian:
  - LEN_HI byte, then LEN_LO byte, forming the 16-bit word count N.
  - Then N instruction words, each sent as high byte then low byte.
- Reset values: state=LEN_HI, rx_ready=1, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0. The N and word registers clear to 0.
- FSM states and transitions:
  - LEN_HI: on accept, N[15:8]←byte; go to LEN_LO.
  - LEN_LO: on accept, N[7:0]←byte, then:
    - full N == 0 → DONE;
    - full N > DEPTH → ERR;
    - otherwise → DATA_HI.
  - DATA_HI: on accept, word[15:8]←byte; go to DATA_LO.
  - DATA_LO: on accept, word[7:0]←byte; go to WRITE.
  - WRITE: lasts exactly one cycle.
    - we=1, waddr=words_loaded[ADDR_W-1:0], wdata=word; the memory captures on the edge that leaves WRITE.
    - On that edge words_loaded increments.
    - If the new count == N → DONE, else → DATA_HI.
  - DONE: terminal until reset.
  - ERR: terminal until reset.
- Output decoding (combinational from state):
  - rx_ready=1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO; 0 in WRITE, DONE, ERR.
  - cpu_hold=1 in every state except DONE.
  - done=1 only in DONE.
  - error=1 only in ERR.
  - we=1 only in WRITE.
  - wdata holds the last assembled word outside WRITE.
- Throughput: minimum 3 cycles per word (two accepts plus one WRITE). Minimum latency from the last LEN_LO accept to done=1 is 3N cycles.
- Release timing: cpu_hold falls on the same edge that done rises, i.e. the edge after the final WRITE cycle. The CPU therefore leaves reset with PC=0 the following cycle.
- Stalls: rx_valid=0 in any receiving state holds the state; there is no timeout.
- Reset mid-load: returns to LEN_HI with all reset values and cpu_hold=1. Words already written stay in memory; there is no erase.
- Reset while in WRITE: reset has priority, so we deasserts that cycle and the write does not occur.
- Bytes after DONE or ERR: not accepted (rx_ready=0). The upstream source must hold or drop them.
- N == DEPTH is legal: the final word goes to address DEPTH-1, and words_loaded reaches DEPTH without wrapping, since its width is ADDR_W+1.
- ERR: cpu_hold stays 1 and no memory writes occur.

Test Plan:
- Reset, then stream 00 02 12 34 AB CD with rx_valid held at 1:
  - Required: we pulses twice, (waddr=0, wdata=0x1234) then (waddr=1, wdata=0xABCD).
  - Required: done=1 and cpu_hold=0 exactly 6 cycles after the LEN_LO accept; words_loaded=2.
- Stream 00 00: done=1 and cpu_hold=0 the cycle after the LEN_LO accept; we never asserts.
- Stream 01 01 (N=257 > DEPTH=256): error=1, rx_ready=0, cpu_hold=1, no we. Extra bytes are not accepted; reset clears error.
- Stream N=3 with rx_valid toggling 1,0,1,0 between bytes:
  - Required: rx_ready=0 during each WRITE cycle, and the stalled states hold.
  - Required: final memory words 0..2 match the stream; done only after the third write.
- Send N=4 and two words, then pulse reset for one cycle during DATA_LO:
  - Required: state returns to LEN_HI, words_loaded=0, cpu_hold=1, no spurious we.
  - Required: reload with N=1, word 0x7FFF writes to waddr=0.
- Stream N=256 with words 0x0000..0x00FF: the last write has waddr=255 and wdata=0x00FF; words_loaded=256; done=1.
